// File: rtl/apb_arbiter.sv
// Two-requester APB arbiter (SPI bridge = m0, crypto engine = m1) onto one shared APB port.
// Define APB_ARB_TIMEOUT_EN to add a forced error response when a slave stalls in ACCESS.
module apb_arbiter #(
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        m0_psel,
  input  logic              m0_penable,
  input  logic              m0_pwrite,
  input  logic [1:0]        m0_pstrb,
  input  logic [ADDR_W-1:0] m0_paddr,
  input  logic [DATA_W-1:0] m0_pwdata,
  output logic              m0_pready,
  output logic              m0_pslverr,
  output logic [DATA_W-1:0] m0_prdata,
  input  logic [1:0]        m1_psel,
  input  logic              m1_penable,
  input  logic              m1_pwrite,
  input  logic [1:0]        m1_pstrb,
  input  logic [ADDR_W-1:0] m1_paddr,
  input  logic [DATA_W-1:0] m1_pwdata,
  output logic              m1_pready,
  output logic              m1_pslverr,
  output logic [DATA_W-1:0] m1_prdata,
  output logic [1:0]        psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [1:0]        pstrb_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic              pslverr_i,
  input  logic [DATA_W-1:0] prdata_i,
  output logic [1:0]        grant_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last;
  logic                r_winner;
  logic [1:0]          r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [1:0]          r_pstrb;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [1:0]          r_grant;

  logic                w_req0;
  logic                w_req1;
  logic                w_win_idx;
  logic                w_timeout;
  logic                w_done;
  logic                w_pready;
  logic                w_pslverr;
  logic [DATA_W-1:0]   w_prdata;

  assign w_req0 = (|m0_psel) & ~m0_penable;
  assign w_req1 = (|m1_psel) & ~m1_penable;
  // On a tie the requester that was not served last wins.
  assign w_win_idx = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_done    = (r_state == S_ACCESS) & (pready_i | w_timeout);

`ifdef APB_ARB_TIMEOUT_EN
  logic [7:0] r_timeout_cnt;

  assign w_timeout = (r_state == S_ACCESS) & ~pready_i & (r_timeout_cnt == 8'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout_cnt <= 8'd0;
    end else if (r_state == S_SETUP) begin
      r_timeout_cnt <= 8'd0;
    end else if ((r_state == S_ACCESS) && !pready_i && !w_timeout) begin
      r_timeout_cnt <= r_timeout_cnt + 8'd1;
    end
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req0 | w_req1) w_state_next = S_SETUP;
      S_SETUP:  w_state_next = S_ACCESS;
      S_ACCESS: if (w_done) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_winner  <= 1'b0;
      r_psel    <= 2'b00;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pstrb   <= 2'b00;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_grant   <= 2'b00;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && (w_state_next == S_SETUP)) begin
        r_winner  <= w_win_idx;
        r_psel    <= w_win_idx ? m1_psel   : m0_psel;
        r_pwrite  <= w_win_idx ? m1_pwrite : m0_pwrite;
        r_pstrb   <= w_win_idx ? m1_pstrb  : m0_pstrb;
        r_paddr   <= w_win_idx ? m1_paddr  : m0_paddr;
        r_pwdata  <= w_win_idx ? m1_pwdata : m0_pwdata;
        r_grant   <= w_win_idx ? 2'b10 : 2'b01;
        r_penable <= 1'b0;
      end else if (r_state == S_SETUP) begin
        r_penable <= 1'b1;
      end else if (w_done) begin
        r_psel    <= 2'b00;
        r_penable <= 1'b0;
        r_grant   <= 2'b00;
        r_last    <= r_winner;
      end
    end
  end

  // Response path is combinational so the owner sees pready in the same cycle as the slave.
  assign w_pready  = pready_i | w_timeout;
  assign w_pslverr = (pslverr_i & pready_i) | w_timeout;
  assign w_prdata  = w_timeout ? DATA_W'(16'h4552) : prdata_i;

  always_comb begin
    m0_pready  = 1'b0;
    m0_pslverr = 1'b0;
    m0_prdata  = '0;
    m1_pready  = 1'b0;
    m1_pslverr = 1'b0;
    m1_prdata  = '0;
    // A requester that dropped psel mid-transfer no longer receives the response.
    if (r_state == S_ACCESS) begin
      if (!r_winner && (|m0_psel)) begin
        m0_pready  = w_pready;
        m0_pslverr = w_pslverr;
        m0_prdata  = w_prdata;
      end else if (r_winner && (|m1_psel)) begin
        m1_pready  = w_pready;
        m1_pslverr = w_pslverr;
        m1_prdata  = w_prdata;
      end
    end
  end

  assign psel_o    = r_psel;
  assign penable_o = r_penable;
  assign pwrite_o  = r_pwrite;
  assign pstrb_o   = r_pstrb;
  assign paddr_o   = r_paddr;
  assign pwdata_o  = r_pwdata;
  assign grant_o   = r_grant;

endmodule
